instruction_encoder: RTL
========================

# instruction_encoder

Pipelined RV32I instruction encoder: it is the inverse of the instruction decoder. It accepts a one-hot operation plus register and immediate fields over a valid/ready handshake, packs them into a 32-bit instruction word, and buffers results in a 2-entry output FIFO. It is used by the boot/program loader and by the self-check bench to generate instruction streams. Its output feeds instruction memory or the decoder.

## Interface
- No parameters; depth fixed at 2 entries.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: request fields valid.
- `in_ready` output 1: encoder can accept; equals FIFO count < 2.
- `op` input `InstructionSet`: one-hot operation select.
- `rd`, `rs1`, `rs2` input 5 each: register addresses; ignored where the format lacks them.
- `imm` input 32: immediate value in decoder convention (sign-extended, byte offset).
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer takes head.
- `inst` output 32: encoded word at head.
- `err` output 1: head word is an encoding error.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- The encoder derives format (R/I/S/B/U/J) from `op`, then sets the opcode, funct3 and funct7 that the decoder expects, with bits [1:0] set to 11.
- Immediate packing:
  - I: `imm[11:0]` goes to [31:20].
  - S: split [31:25]/[11:7].
  - B: `imm[12|10:5|4:1|11]`.
  - U: `imm[31:12]`.
  - J: `imm[20|10:1|11|19:12]`.
- Shift-immediates: `imm[4:0]` is shamt. SRAI sets funct7=0100000.
- FENCE: `imm[11:0]` gives fm/pred/succ, plus rd and rs1.
- Fixed words ignore all fields: FENCE_TSO=0x8330000F, PAUSE=0x0100000F, ECALL=0x00000073, EBREAK=0x00100073.
- If `op` is not exactly one-hot (zero or multiple bits), the word is 0x00000000 with `err`=1.
- Every word, including error words, is pushed; `err` is stored alongside it.
- FIFO:
  - 2 entries, head/tail pointers, 2-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - When full, `in_ready`=0 even if a pop occurs in that cycle (no fall-through).
  - When empty, `out_valid`=0. No bypass path.

## Timing
- Reset values: `out_valid`=0, `inst`=0, `err`=0, `in_ready`=1, count=0.
- Latency: a word accepted at edge N is visible with `out_valid`=1 after edge N.
- Throughput: 1 word/cycle sustained when `out_ready`=1.
- Handshake rules:
  - `inst`/`err` stay stable while `out_valid && !out_ready`.
  - Inputs are sampled only on a transfer.
- Reset asserted mid-stream drops all entries; `out_valid`=0 after the reset edge.

## Configuration
- `ENCODER_RANGE_CHECK_EN` defined:
  - `err`=1 and word=0 when the immediate is not representable. Limits:
    - I/S: signed 12-bit.
    - B: signed 13-bit and even.
    - J: signed 21-bit and even.
    - U: `imm[11:0]`=0.
    - Shifts: `imm[31:5]`=0.
  - FENCE and the fixed-word ops are exempt.
- Undefined: out-of-range immediates are silently truncated to the field bits; `err` reports only non-one-hot `op`.

## Structure
- `InstructionSet` and `EncodingType` come from the shared `Instruction` constants package.
- Add opcode/funct3/funct7 localparams and the fixed-word constants to that package, so the decoder and encoder share them.
- Sub-module `immediate_pack`: combinational, format plus `imm` in, scattered bit-field out. It is the inverse of immediate extraction.

## Test plan
- ADDI: `op.ADDI`, rd=1, rs1=0, imm=5 → `inst`=0x00500093, `err`=0, one cycle after accept.
- SUB: `op.SUB`, rd=3, rs1=1, rs2=2 → 0x402081B3. BEQ: rs1=1, rs2=2, imm=0xFFFFFFF8 → 0xFE208CE3.
- Backpressure: `out_ready`=0, offer 3 words → `in_ready`=0 after 2 accepts. Raise `out_ready` → all 3 emerge in order, no loss or duplication.
- Invalid op: `op.ADD|op.SUB` → `inst`=0x00000000, `err`=1. ECALL with nonzero fields → 0x00000073.
- Range check: ADDI rd=1, imm=0x800:
  - With `ENCODER_RANGE_CHECK_EN`: `err`=1, `inst`=0.
  - Without it: `inst`=0x80000093, `err`=0.
- Reset mid-operation: FIFO full, assert `reset` one cycle → `out_valid`=0, `in_ready`=1 after the edge. The next accepted word emerges correctly.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: shared RV32I instruction set, encoding formats, opcode/funct fields and fixed words.
package instruction_encoder_pkg;

    typedef struct packed {
        logic LUI, AUIPC, JAL, JALR;
        logic BEQ, BNE, BLT, BGE, BLTU, BGEU;
        logic LB, LH, LW, LBU, LHU;
        logic SB, SH, SW;
        logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
        logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
        logic FENCE, FENCE_TSO, PAUSE, ECALL, EBREAK;
    } InstructionSet;

    localparam int NUM_OPS = $bits(InstructionSet);

    typedef enum logic [3:0] {
        ENC_R, ENC_I, ENC_SH, ENC_S, ENC_B, ENC_U, ENC_J, ENC_FENCE, ENC_FIXED
    } EncodingType;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISC    = 7'b0001111;

    localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] WORD_FENCE_TSO = 32'h8330000F;
    localparam logic [31:0] WORD_PAUSE     = 32'h0100000F;
    localparam logic [31:0] WORD_ECALL     = 32'h00000073;
    localparam logic [31:0] WORD_EBREAK    = 32'h00100073;

    typedef struct packed {
        EncodingType fmt;
        logic [31:0] base;
    } op_info_t;

    function automatic op_info_t mk(EncodingType f, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
        return '{f, {f7, 10'b0, f3, 5'b0, opc}};
    endfunction

    function automatic op_info_t fixed_word(logic [31:0] w);
        return '{ENC_FIXED, w};
    endfunction

    function automatic logic fits_signed(logic [31:0] v, int n);
        logic [31:0] s;
        s = 32'($signed(v) >>> (n - 1));
        return (s == '0) || (s == '1);
    endfunction

    // Entry k describes the k-th field of InstructionSet (first field is the MSB).
    localparam op_info_t OP_TABLE [NUM_OPS] = '{
        mk(ENC_U, OPC_LUI, 3'd0, F7_BASE), mk(ENC_U, OPC_AUIPC, 3'd0, F7_BASE),
        mk(ENC_J, OPC_JAL, 3'd0, F7_BASE), mk(ENC_I, OPC_JALR, 3'd0, F7_BASE),
        mk(ENC_B, OPC_BRANCH, F3_BEQ, F7_BASE), mk(ENC_B, OPC_BRANCH, F3_BNE, F7_BASE),
        mk(ENC_B, OPC_BRANCH, F3_BLT, F7_BASE), mk(ENC_B, OPC_BRANCH, F3_BGE, F7_BASE),
        mk(ENC_B, OPC_BRANCH, F3_BLTU, F7_BASE), mk(ENC_B, OPC_BRANCH, F3_BGEU, F7_BASE),
        mk(ENC_I, OPC_LOAD, F3_B, F7_BASE), mk(ENC_I, OPC_LOAD, F3_H, F7_BASE),
        mk(ENC_I, OPC_LOAD, F3_W, F7_BASE), mk(ENC_I, OPC_LOAD, F3_BU, F7_BASE),
        mk(ENC_I, OPC_LOAD, F3_HU, F7_BASE),
        mk(ENC_S, OPC_STORE, F3_B, F7_BASE), mk(ENC_S, OPC_STORE, F3_H, F7_BASE),
        mk(ENC_S, OPC_STORE, F3_W, F7_BASE),
        mk(ENC_I, OPC_OP_IMM, F3_ADD, F7_BASE), mk(ENC_I, OPC_OP_IMM, F3_SLT, F7_BASE),
        mk(ENC_I, OPC_OP_IMM, F3_SLTU, F7_BASE), mk(ENC_I, OPC_OP_IMM, F3_XOR, F7_BASE),
        mk(ENC_I, OPC_OP_IMM, F3_OR, F7_BASE), mk(ENC_I, OPC_OP_IMM, F3_AND, F7_BASE),
        mk(ENC_SH, OPC_OP_IMM, F3_SLL, F7_BASE), mk(ENC_SH, OPC_OP_IMM, F3_SR, F7_BASE),
        mk(ENC_SH, OPC_OP_IMM, F3_SR, F7_ALT),
        mk(ENC_R, OPC_OP, F3_ADD, F7_BASE), mk(ENC_R, OPC_OP, F3_ADD, F7_ALT),
        mk(ENC_R, OPC_OP, F3_SLL, F7_BASE), mk(ENC_R, OPC_OP, F3_SLT, F7_BASE),
        mk(ENC_R, OPC_OP, F3_SLTU, F7_BASE), mk(ENC_R, OPC_OP, F3_XOR, F7_BASE),
        mk(ENC_R, OPC_OP, F3_SR, F7_BASE), mk(ENC_R, OPC_OP, F3_SR, F7_ALT),
        mk(ENC_R, OPC_OP, F3_OR, F7_BASE), mk(ENC_R, OPC_OP, F3_AND, F7_BASE),
        mk(ENC_FENCE, OPC_MISC, 3'd0, F7_BASE),
        fixed_word(WORD_FENCE_TSO), fixed_word(WORD_PAUSE),
        fixed_word(WORD_ECALL), fixed_word(WORD_EBREAK)
    };

endpackage

// File: rtl/instruction_encoder_immediate_pack.sv
// immediate_pack: scatters a decoder-convention immediate into the bit positions of its format.
import instruction_encoder_pkg::*;

module immediate_pack (
    input  EncodingType fmt_i,
    input  logic [31:0] imm_i,
    output logic [31:0] field_o
);
    always_comb begin
        field_o = '0;
        case (fmt_i)
            ENC_I, ENC_FENCE: field_o = {imm_i[11:0], 20'b0};
            ENC_SH:           field_o = {7'b0, imm_i[4:0], 20'b0};
            ENC_S:            field_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
            ENC_B:            field_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
            ENC_U:            field_o = {imm_i[31:12], 12'b0};
            ENC_J:            field_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
            default:          field_o = '0;
        endcase
    end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs one-hot op + fields into RV32I words behind a 2-entry FIFO.
// Define ENCODER_RANGE_CHECK_EN to flag unrepresentable immediates as errors.
import instruction_encoder_pkg::*;

module instruction_encoder (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  InstructionSet op,
    input  logic [4:0]    rd,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    input  logic [31:0]   imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   inst,
    output logic          err
);
    logic [NUM_OPS-1:0] op_v;
    op_info_t           info;
    logic [31:0]        imm_bits, enc_word, word;
    logic               one_hot, range_bad, err_w, use_rd, use_rs1, use_rs2, push, pop;
    logic [32:0]        mem_q [2];
    logic               head_q, tail_q;
    logic [1:0]         count_q, count_d;

    assign op_v    = op;
    assign one_hot = (op_v != '0) && ((op_v & (op_v - NUM_OPS'(1))) == '0);

    always_comb begin
        info = '{ENC_FIXED, 32'h0};
        for (int k = 0; k < NUM_OPS; k++)
            if (op_v[NUM_OPS-1-k]) info = OP_TABLE[k];
    end

    immediate_pack u_pack (
        .fmt_i   (info.fmt),
        .imm_i   (imm),
        .field_o (imm_bits)
    );

    assign use_rd  = info.fmt inside {ENC_R, ENC_I, ENC_SH, ENC_U, ENC_J, ENC_FENCE};
    assign use_rs1 = info.fmt inside {ENC_R, ENC_I, ENC_SH, ENC_S, ENC_B, ENC_FENCE};
    assign use_rs2 = info.fmt inside {ENC_R, ENC_S, ENC_B};
    assign enc_word = info.base | imm_bits
                    | ({12'b0, rs1, 15'b0} & {32{use_rs1}})
                    | ({7'b0, rs2, 20'b0} & {32{use_rs2}})
                    | ({20'b0, rd, 7'b0} & {32{use_rd}});

`ifdef ENCODER_RANGE_CHECK_EN
    always_comb begin
        range_bad = 1'b0;
        case (info.fmt)
            ENC_I, ENC_S: range_bad = !fits_signed(imm, 12);
            ENC_B:        range_bad = !fits_signed(imm, 13) || imm[0];
            ENC_J:        range_bad = !fits_signed(imm, 21) || imm[0];
            ENC_U:        range_bad = |imm[11:0];
            ENC_SH:       range_bad = |imm[31:5];
            default:      range_bad = 1'b0;
        endcase
    end
`else
    assign range_bad = 1'b0;
`endif

    assign err_w = !one_hot || range_bad;
    assign word  = err_w ? 32'h0 : enc_word;

    // Full blocks new input even when a pop happens in the same cycle.
    assign in_ready  = count_q != 2'd2;
    assign out_valid = count_q != 2'd0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count_d   = count_q + 2'(push) - 2'(pop);
    assign {err, inst} = out_valid ? mem_q[head_q] : 33'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                mem_q[tail_q] <= {err_w, word};
                tail_q        <= ~tail_q;
            end
            if (pop) head_q <= ~head_q;
            count_q <= count_d;
        end
    end
endmodule
